add_mul_sub_seq: RTL

ADD_MUL_SUB_SEQ -- requirements
Module: add_mul_sub_seq

---
 rtl/add_mul_sub_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/add_mul_sub_seq.sv
// Sequential add/subtract/multiply unit: add, sub and illegal finish in one cycle,
// multiply runs a radix-2 shift-add over WIDTH cycles. One request in flight at a time.
module add_mul_sub_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           operation,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 err
);

   localparam int RESULT_W = 2 * WIDTH;
   localparam int CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [RESULT_W-1:0]   acc_q, acc_d;
   logic [RESULT_W-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]      mplier_q, mplier_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic [RESULT_W-1:0]   a_ext;
   logic [RESULT_W-1:0]   b_ext;

   assign accept = in_valid && (state_q == IDLE);
   assign a_ext  = {{WIDTH{1'b0}}, a};
   assign b_ext  = {{WIDTH{1'b0}}, b};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (operation == OP_MUL) ? MUL : DONE;
            end
         end
         MUL: begin
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      result    = acc_q;
      err       = err_q;
   end

   // Datapath: operands are captured only on accept, so inputs seen in MUL/DONE never matter.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               err_d = 1'b0;
               cnt_d = '0;
               case (operation)
                  OP_ADD: acc_d = a_ext + b_ext;
                  OP_SUB: acc_d = a_ext - b_ext;
                  OP_MUL: begin
                     acc_d    = '0;
                     mcand_d  = a_ext;
                     mplier_d = b;
                  end
                  default: begin
                     acc_d = '0;
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

endmodule
